// File: rtl/vx_gbar_unit_if.sv
// Global barrier bus between core schedulers (master) and the cluster responder (slave).
interface vx_gbar_unit_if #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8
);
    localparam int NC_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic [NUM_CORES-1:0]               req_valid;
    logic [NUM_CORES-1:0][NB_WIDTH-1:0] req_id;
    logic [NUM_CORES-1:0][NC_WIDTH-1:0] req_size_m1;
    logic [NUM_CORES-1:0]               req_ready;
    logic                               rsp_valid;
    logic [NB_WIDTH-1:0]                rsp_id;
    logic [NUM_BARRIERS-1:0]            pending;
    logic                               err_valid;
    logic [1:0]                         err_code;
    logic [NC_WIDTH-1:0]                err_core;

    modport master (
        output req_valid, req_id, req_size_m1,
        input  req_ready, rsp_valid, rsp_id, pending, err_valid, err_code, err_core
    );

    modport slave (
        input  req_valid, req_id, req_size_m1,
        output req_ready, rsp_valid, rsp_id, pending, err_valid, err_code, err_core
    );
endinterface

// File: rtl/vx_gbar_unit.sv
// Global barrier responder: round-robin accepts one core arrival per cycle,
// tracks per-barrier arrival masks and broadcasts a one-cycle release.
module vx_gbar_unit #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    vx_gbar_unit_if.slave   bus
);
    localparam int NC_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DUP  = 2'b01;
    localparam logic [1:0] ERR_MISM = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;

    logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask;
    logic [NUM_BARRIERS-1:0][NC_WIDTH-1:0]  size_q;
    logic [NC_WIDTH-1:0]                    rr_ptr;

    logic [NUM_CORES-1:0] grant;
    logic [NC_WIDTH-1:0]  gidx;
    logic                 fire;
    int                   idx;

    // Scan from rr_ptr upward so the core after the last winner has priority.
    always_comb begin
        grant = '0;
        gidx  = '0;
        fire  = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CORES;
            if (!fire && bus.req_valid[idx]) begin
                fire       = 1'b1;
                grant[idx] = 1'b1;
                gidx       = NC_WIDTH'(idx);
            end
        end
    end

    assign bus.req_ready = reset_n ? grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (fire)
            rr_ptr <= (gidx == NC_WIDTH'(NUM_CORES - 1)) ? '0 : gidx + 1'b1;
    end

    logic [NB_WIDTH-1:0]  sel_id;
    logic [NC_WIDTH-1:0]  sel_sz;
    logic [NUM_CORES-1:0] sel_mask;
    logic [NC_WIDTH-1:0]  sel_size;
    logic [NC_WIDTH-1:0]  lat_sz;
    logic [NC_WIDTH-1:0]  eff;
    logic [NC_WIDTH:0]    cnt;
    logic                 first, dup, ovf, mism, last;
    logic [1:0]           code;

    always_comb begin
        sel_id   = bus.req_id[gidx];
        sel_sz   = bus.req_size_m1[gidx];
        sel_mask = mask[sel_id];
        sel_size = size_q[sel_id];
        first    = ~|sel_mask;
        dup      = sel_mask[gidx];
        ovf      = {{(32-NC_WIDTH){1'b0}}, sel_sz} >= 32'(NUM_CORES);
        mism     = !first && (sel_sz != sel_size);
        lat_sz   = ovf ? NC_WIDTH'(NUM_CORES - 1) : sel_sz;
        eff      = first ? lat_sz : sel_size;
        cnt      = '0;
        for (int k = 0; k < NUM_CORES; k++)
            cnt = cnt + {{NC_WIDTH{1'b0}}, sel_mask[k]};
        // Arrivals so far equal size-1: this arrival is the last one.
        last     = !dup && (cnt == {1'b0, eff});
        if (dup)       code = ERR_DUP;
        else if (ovf)  code = ERR_OVF;
        else if (mism) code = ERR_MISM;
        else           code = ERR_NONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask   <= '0;
            size_q <= '0;
        end else if (fire && !dup) begin
            if (last)
                mask[sel_id] <= '0;
            else
                mask[sel_id][gidx] <= 1'b1;
            if (first)
                size_q[sel_id] <= lat_sz;
        end
    end

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_pend
        assign bus.pending[b] = |mask[b];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.err_valid <= 1'b0;
            bus.err_code  <= ERR_NONE;
            bus.err_core  <= '0;
        end else begin
            bus.rsp_valid <= fire && last;
            if (fire && last)
                bus.rsp_id <= sel_id;
            bus.err_valid <= fire && (code != ERR_NONE);
            bus.err_code  <= fire ? code : ERR_NONE;
            bus.err_core  <= (fire && (code != ERR_NONE)) ? gidx : '0;
        end
    end
endmodule
